// File: rtl/dc_offset_insert_if.sv
// Sample stream bundle for dc_offset_insert: AC input samples in, offset-restored samples out.
interface dc_offset_insert_if #(
    parameter int unsigned DIN_WIDTH = 12
);
    logic signed [DIN_WIDTH-1:0] din;
    logic                        din_valid;
    logic signed [DIN_WIDTH-1:0] dout;
    logic                        dout_valid;
    logic                        sat;

    modport master (
        output din, din_valid,
        input  dout, dout_valid, sat
    );

    modport slave (
        input  din, din_valid,
        output dout, dout_valid, sat
    );
endinterface

// File: rtl/dc_offset_insert.sv
// Adds a slew-limited programmable DC offset to a zero-mean sample stream,
// saturating the sum to the sample width over a two-stage pipeline.
module dc_offset_insert #(
    parameter int unsigned DIN_WIDTH  = 12,
    parameter int unsigned STEP_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dc_offset_insert_if.slave           bus,
    input  logic signed [DIN_WIDTH-1:0] offset_target,
    input  logic                        offset_load,
    input  logic [STEP_WIDTH-1:0]       ramp_step,
    output logic signed [DIN_WIDTH-1:0] offset_now,
    output logic                        ramping
);

    localparam int unsigned EW = DIN_WIDTH + 1;

    typedef enum logic [0:0] {HOLD = 1'b0, RAMP = 1'b1} state_t;

    state_t                      state;
    logic signed [DIN_WIDTH-1:0] target_r;
    logic signed [EW-1:0]        s1;
    logic                        v1;

    logic signed [EW-1:0] target_ext;
    logic signed [EW-1:0] now_ext;
    logic signed [EW-1:0] diff;
    logic signed [EW-1:0] abs_diff;
    logic signed [EW-1:0] step_ext;
    logic signed [EW-1:0] stepped;
    logic signed [EW-1:0] sum;
    logic                 step_done;
    logic                 clip;

    // Extended-width ramp and sum arithmetic so full-scale targets cannot overflow
    always_comb begin
        target_ext = {target_r[DIN_WIDTH-1], target_r};
        now_ext    = {offset_now[DIN_WIDTH-1], offset_now};
        diff       = target_ext - now_ext;
        abs_diff   = diff[EW-1] ? -diff : diff;
        step_ext   = EW'(ramp_step);
        step_done  = (ramp_step == '0) || (abs_diff <= step_ext);
        stepped    = diff[EW-1] ? (now_ext - step_ext) : (now_ext + step_ext);
        sum        = {bus.din[DIN_WIDTH-1], bus.din} + now_ext;
        clip       = s1[EW-1] != s1[EW-2];
    end

    // Offset control FSM; a load always wins over a step in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HOLD;
            ramping    <= 1'b0;
            target_r   <= '0;
            offset_now <= '0;
        end else if (offset_load) begin
            target_r <= offset_target;
            if (ramp_step == '0) begin
                offset_now <= offset_target;
                state      <= HOLD;
                ramping    <= 1'b0;
            end else if (offset_target != offset_now) begin
                state   <= RAMP;
                ramping <= 1'b1;
            end else begin
                state   <= HOLD;
                ramping <= 1'b0;
            end
        end else if (state == RAMP && bus.din_valid) begin
            if (step_done) begin
                offset_now <= target_r;
                state      <= HOLD;
                ramping    <= 1'b0;
            end else begin
                offset_now <= stepped[DIN_WIDTH-1:0];
            end
        end
    end

    // Stage 1 sums with the pre-update offset; stage 2 clamps to the sample range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1             <= '0;
            v1             <= 1'b0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.sat        <= 1'b0;
        end else begin
            v1             <= bus.din_valid;
            bus.dout_valid <= v1;
            if (bus.din_valid) begin
                s1 <= sum;
            end
            if (v1) begin
                bus.sat <= clip;
                if (clip) begin
                    bus.dout <= s1[EW-1] ? {1'b1, {(DIN_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DIN_WIDTH-1){1'b1}}};
                end else begin
                    bus.dout <= s1[DIN_WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_dc_offset_insert.sv
// Directed bench for dc_offset_insert with hand-computed expectations.
module tb_dc_offset_insert;

    localparam int unsigned DW = 12;
    localparam int unsigned SW = 8;

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] offset_target;
    logic                 offset_load;
    logic [SW-1:0]        ramp_step;
    logic signed [DW-1:0] offset_now;
    logic                 ramping;

    int n_vec;
    int n_err;

    dc_offset_insert_if #(.DIN_WIDTH(DW)) bus ();

    dc_offset_insert #(.DIN_WIDTH(DW), .STEP_WIDTH(SW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .offset_target (offset_target),
        .offset_load   (offset_load),
        .ramp_step     (ramp_step),
        .offset_now    (offset_now),
        .ramping       (ramping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then step past the edge to observe results
    task automatic cyc(input logic signed [DW-1:0] din, input logic vld, input logic ld,
                       input logic signed [DW-1:0] tgt, input logic [SW-1:0] step);
        bus.din       = din;
        bus.din_valid = vld;
        offset_load   = ld;
        offset_target = tgt;
        ramp_step     = step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.din = '0;
        bus.din_valid = 1'b0;
        offset_load = 1'b0;
        offset_target = '0;
        ramp_step = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", bus.dout, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_sat", bus.sat, 0);
        chk("rst_offset", offset_now, 0);
        chk("rst_ramping", ramping, 0);
        rst_n = 1'b1;

        // Jump load of 100 with continuous din=5
        cyc(5, 1, 1, 100, 0);
        chk("jump_offset", offset_now, 100);
        chk("jump_ramping", ramping, 0);
        cyc(5, 1, 0, 0, 0);
        chk("jump_first_dout", bus.dout, 5);
        chk("jump_first_valid", bus.dout_valid, 1);
        cyc(5, 1, 0, 0, 0);
        chk("jump_dout", bus.dout, 105);
        chk("jump_sat", bus.sat, 0);
        cyc(0, 0, 0, 0, 0);
        chk("jump_tail_valid", bus.dout_valid, 1);
        cyc(0, 0, 0, 0, 0);
        chk("jump_gap_valid", bus.dout_valid, 0);
        chk("jump_gap_hold", bus.dout, 105);

        // Ramp up 0 -> 40 with step 16
        cyc(0, 0, 1, 0, 0);
        chk("ru_preset", offset_now, 0);
        cyc(0, 1, 1, 40, 16);
        chk("ru_load_offset", offset_now, 0);
        chk("ru_load_ramping", ramping, 1);
        cyc(0, 1, 0, 0, 16);
        chk("ru_step1", offset_now, 16);
        chk("ru_step1_ramping", ramping, 1);
        cyc(0, 1, 0, 0, 16);
        chk("ru_step2", offset_now, 32);
        chk("ru_step2_ramping", ramping, 1);
        cyc(0, 1, 0, 0, 16);
        chk("ru_step3", offset_now, 40);
        chk("ru_step3_ramping", ramping, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Saturation at both rails and just inside
        cyc(0, 0, 1, 2000, 0);
        cyc(100, 1, 0, 0, 0);
        cyc(47, 1, 0, 0, 0);
        chk("sat_hi_dout", bus.dout, 2047);
        chk("sat_hi_flag", bus.sat, 1);
        cyc(0, 0, 0, 0, 0);
        chk("sat_edge_dout", bus.dout, 2047);
        chk("sat_edge_flag", bus.sat, 0);
        cyc(0, 0, 1, -2048, 0);
        cyc(-1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("sat_lo_dout", bus.dout, -2048);
        chk("sat_lo_flag", bus.sat, 1);
        cyc(0, 0, 0, 0, 0);
        chk("sat_lo_hold_valid", bus.dout_valid, 0);
        chk("sat_lo_hold_flag", bus.sat, 1);

        // Full-scale ramp -2048 -> 2047 with step 255 (16 full steps, then a 15 remainder)
        cyc(0, 1, 1, 2047, 255);
        chk("fs_load_ramping", ramping, 1);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 255);
        chk("fs_step16", offset_now, 2032);
        chk("fs_step16_ramping", ramping, 1);
        cyc(0, 1, 0, 0, 255);
        chk("fs_final", offset_now, 2047);
        chk("fs_final_ramping", ramping, 0);

        // Retarget mid-ramp: toward 100 by 10, retarget to -50 at 30
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 1, 100, 10);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 10);
        chk("rt_at30", offset_now, 30);
        cyc(0, 1, 1, -50, 10);
        chk("rt_load_no_step", offset_now, 30);
        chk("rt_load_ramping", ramping, 1);
        cyc(0, 1, 0, 0, 10);
        chk("rt_first_down", offset_now, 20);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 10);
        chk("rt_at_m40", offset_now, -40);
        chk("rt_at_m40_ramping", ramping, 1);
        cyc(0, 1, 0, 0, 10);
        chk("rt_done", offset_now, -50);
        chk("rt_done_ramping", ramping, 0);

        // ramp_step of 0 mid-ramp completes the ramp
        cyc(0, 1, 1, 500, 10);
        cyc(0, 1, 0, 0, 10);
        chk("z_step", offset_now, -40);
        cyc(0, 1, 0, 0, 0);
        chk("z_complete", offset_now, 500);
        chk("z_ramping", ramping, 0);

        // Valid gaps during a ramp with step 8: pattern 1-0-0-1
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 1, 40, 8);
        chk("gap_load_valid", bus.dout_valid, 0);
        cyc(1, 1, 0, 0, 8);
        chk("gap_a_offset", offset_now, 8);
        chk("gap_a_valid", bus.dout_valid, 1);
        cyc(0, 0, 0, 0, 8);
        chk("gap_b_offset", offset_now, 8);
        chk("gap_b_valid", bus.dout_valid, 1);
        chk("gap_b_dout", bus.dout, 1);
        cyc(0, 0, 0, 0, 8);
        chk("gap_c_offset", offset_now, 8);
        chk("gap_c_valid", bus.dout_valid, 0);
        chk("gap_c_hold", bus.dout, 1);
        cyc(2, 1, 0, 0, 8);
        chk("gap_d_offset", offset_now, 16);
        chk("gap_d_valid", bus.dout_valid, 0);
        cyc(0, 0, 0, 0, 8);
        chk("gap_e_valid", bus.dout_valid, 1);
        chk("gap_e_dout", bus.dout, 10);
        chk("gap_e_sat", bus.sat, 0);

        // Async reset mid-ramp
        cyc(3, 1, 0, 0, 8);
        chk("ar_pre_offset", offset_now, 24);
        chk("ar_pre_ramping", ramping, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_dout", bus.dout, 0);
        chk("ar_valid", bus.dout_valid, 0);
        chk("ar_sat", bus.sat, 0);
        chk("ar_offset", offset_now, 0);
        chk("ar_ramping", ramping, 0);
        bus.din_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(7, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("ar_post_dout", bus.dout, 7);
        chk("ar_post_valid", bus.dout_valid, 1);
        chk("ar_post_offset", offset_now, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
